// File: rtl/dmem_lsu_if.sv
// CPU-side request/response bundle of the load/store unit.
// Single outstanding request, no response backpressure.
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit driving a byte-lane dmem: store resp 1 cycle, load resp 2, error resp 0 after accept.
// One request at a time; req_ready only in IDLE, responses cannot be stalled.
module dmem_lsu #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    dmem_lsu_if.slave         lsu,
    output logic [ADDR_W-1:0] daddr,
    output logic [3:0]        we,
    output logic [31:0]       indata,
    input  logic [31:0]       outdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              store_q, store_d;
    logic [3:0]        we_q, we_d;
    logic [31:0]       indata_q, indata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              legal;
    logic [3:0]        st_we;
    logic [31:0]       st_dat;
    logic [15:0]       lane_dat;
    logic [31:0]       ld_ext;
    logic              unused_addr;

    assign unused_addr = ^lsu.req_addr[31:ADDR_W+2];

    // Decode of the incoming request: legality, lane enables, replicated data.
    always_comb begin
        legal  = 1'b0;
        st_we  = 4'b0000;
        st_dat = 32'h0;
        case (lsu.req_funct3)
            3'b000: begin
                legal  = 1'b1;
                st_we  = 4'b0001 << lsu.req_addr[1:0];
                st_dat = {4{lsu.req_wdata[7:0]}};
            end
            3'b001: begin
                legal  = ~lsu.req_addr[0];
                st_we  = lsu.req_addr[1] ? 4'b1100 : 4'b0011;
                st_dat = {2{lsu.req_wdata[15:0]}};
            end
            3'b010: begin
                legal  = (lsu.req_addr[1:0] == 2'b00);
                st_we  = 4'b1111;
                st_dat = lsu.req_wdata;
            end
            3'b100:  legal = ~lsu.req_store;
            3'b101:  legal = ~lsu.req_store & ~lsu.req_addr[0];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        lane_dat = 16'(outdata >> {off_q, 3'b000});
        case (funct3_q)
            3'b000:  ld_ext = {{24{lane_dat[7]}}, lane_dat[7:0]};
            3'b100:  ld_ext = {24'h0, lane_dat[7:0]};
            3'b001:  ld_ext = {{16{lane_dat[15]}}, lane_dat};
            3'b101:  ld_ext = {16'h0, lane_dat};
            default: ld_ext = outdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        daddr_d  = daddr_q;
        off_d    = off_q;
        funct3_d = funct3_q;
        store_d  = store_q;
        we_d     = we_q;
        indata_d = indata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (lsu.req_valid) begin
                    daddr_d  = lsu.req_addr[ADDR_W+1:2];
                    off_d    = lsu.req_addr[1:0];
                    funct3_d = lsu.req_funct3;
                    store_d  = lsu.req_store;
                    rdata_d  = 32'h0;
                    err_d    = ~legal;
                    we_d     = (legal & lsu.req_store) ? st_we : 4'b0000;
                    indata_d = (legal & lsu.req_store) ? st_dat : 32'h0;
                    state_d  = legal ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                we_d    = 4'b0000;
                state_d = store_q ? RESP : CAPTURE;
            end
            CAPTURE: begin
                rdata_d = ld_ext;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            daddr_q  <= '0;
            off_q    <= 2'b00;
            funct3_q <= 3'b000;
            store_q  <= 1'b0;
            we_q     <= 4'b0000;
            indata_q <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            daddr_q  <= daddr_d;
            off_q    <= off_d;
            funct3_q <= funct3_d;
            store_q  <= store_d;
            we_q     <= we_d;
            indata_q <= indata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Gating with reset keeps a reset during ACCESS from committing the write.
    assign we             = we_q & {4{~reset}};
    assign daddr          = daddr_q;
    assign indata         = indata_q;
    assign lsu.req_ready  = (state_q == IDLE) & ~reset;
    assign lsu.resp_valid = (state_q == RESP) & ~reset;
    assign lsu.resp_rdata = rdata_q;
    assign lsu.resp_err   = err_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural one-cycle-latency byte-lane memory.
module tb_dmem_lsu;
    localparam int AW = 10;

    logic          clk;
    logic          reset;
    logic [AW-1:0] daddr;
    logic [3:0]    we;
    logic [31:0]   indata;
    logic [31:0]   outdata;
    logic [31:0]   mem [0:(1<<AW)-1];

    int n_vec  = 0;
    int n_miss = 0;

    dmem_lsu_if bus ();

    dmem_lsu #(.ADDR_W(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .lsu     (bus),
        .daddr   (daddr),
        .we      (we),
        .indata  (indata),
        .outdata (outdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[daddr][8*i +: 8] <= indata[8*i +: 8];
        outdata <= mem[daddr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request from IDLE and watch it until its response pulse.
    task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err,
                       output int lat, output logic [3:0] we_or, output int we_cyc,
                       output logic [31:0] ind, output logic [AW-1:0] da);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat    = -1;
        we_or  = 4'b0000;
        we_cyc = 0;
        ind    = indata;
        da     = daddr;
        rd     = 32'h0;
        err    = 1'b0;
        for (int k = 0; k < 10; k++) begin
            we_or = we_or | we;
            if (we != 4'b0000) we_cyc++;
            if (bus.resp_valid) begin
                lat = k;
                rd  = bus.resp_rdata;
                err = bus.resp_err;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat < 0) chk("resp_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        chk("resp_pulse_once", {31'h0, bus.resp_valid}, 32'd0);
    endtask

    logic [31:0]   rd, ind;
    logic          err;
    int            lat, we_cyc;
    logic [3:0]    we_or;
    logic [AW-1:0] da;

    task automatic ld(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] exp);
        run(1'b0, f3, addr, 32'h0, rd, err, lat, we_or, we_cyc, ind, da);
        chk({tag, "_data"}, rd, exp);
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_we"}, {28'h0, we_or}, 32'h0);
    endtask

    task automatic bad(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr);
        run(st, f3, addr, 32'hA5A5A5A5, rd, err, lat, we_or, we_cyc, ind, da);
        chk({tag, "_err"}, {31'h0, err}, 32'd1);
        chk({tag, "_rdata"}, rd, 32'h0);
        chk({tag, "_lat"}, lat, 0);
        chk({tag, "_we"}, {28'h0, we_or}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  bf3 [4];
        logic        bst [4];
        logic [31:0] bad_a [4];
        logic [31:0] bwd [4];
        logic [31:0] brd [4];
        int idx, nresp;
        logic rdy_at;

        for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, bus.req_ready}, 32'd0);
        chk("rst_valid", {31'h0, bus.resp_valid}, 32'd0);
        chk("rst_outs", {bus.resp_rdata | indata | {22'h0, daddr}}, 32'h0);
        chk("rst_we_err", {27'h0, we, bus.resp_err}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", {31'h0, bus.req_ready}, 32'd1);

        // Word store then load.
        run(1'b1, 3'b010, 32'h40, 32'hDEADBEEF, rd, err, lat, we_or, we_cyc, ind, da);
        chk("sw_we", {28'h0, we_or}, 32'hF);
        chk("sw_we_cycles", we_cyc, 1);
        chk("sw_daddr", {22'h0, da}, 32'h10);
        chk("sw_lat", lat, 1);
        chk("sw_err_rdata", {rd[30:0], err}, 32'h0);
        chk("sw_mem", mem[16], 32'hDEADBEEF);
        ld("lw", 3'b010, 32'h40, 32'hDEADBEEF);

        // Byte lanes.
        run(1'b1, 3'b000, 32'h43, 32'h00000080, rd, err, lat, we_or, we_cyc, ind, da);
        chk("sb_we", {28'h0, we_or}, 32'h8);
        chk("sb_indata", ind, 32'h80808080);
        ld("lb", 3'b000, 32'h43, 32'hFFFFFF80);
        ld("lbu", 3'b100, 32'h43, 32'h00000080);
        ld("lw_after_sb", 3'b010, 32'h40, 32'h80ADBEEF);

        // Halfwords.
        run(1'b1, 3'b001, 32'h42, 32'h00008001, rd, err, lat, we_or, we_cyc, ind, da);
        chk("sh_we", {28'h0, we_or}, 32'hC);
        chk("sh_indata", ind, 32'h80018001);
        ld("lh", 3'b001, 32'h42, 32'hFFFF8001);
        ld("lhu", 3'b101, 32'h42, 32'h00008001);
        ld("lh_lo", 3'b001, 32'h40, 32'hFFFFBEEF);
        ld("lw_wrap", 3'b010, 32'h1040, 32'h8001BEEF);

        // Misaligned and illegal requests.
        bad("lw_mis", 1'b0, 3'b010, 32'h41);
        bad("sh_mis", 1'b1, 3'b001, 32'h43);
        bad("st_f3_100", 1'b1, 3'b100, 32'h40);
        bad("f3_011", 1'b0, 3'b011, 32'h40);
        ld("lw_after_err", 3'b010, 32'h40, 32'h8001BEEF);

        // Reset during the ACCESS cycle of a store.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h40;
        bus.req_wdata  = 32'h12345678;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("rst_mid_we_pre", {28'h0, we}, 32'hF);
        reset = 1'b1;
        #1;
        chk("rst_mid_we_gated", {28'h0, we}, 32'h0);
        chk("rst_mid_ready", {31'h0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_mid_outs", bus.resp_rdata | indata | {22'h0, daddr}, 32'h0);
        chk("rst_mid_valid", {31'h0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("rst_mid_no_resp", {31'h0, bus.resp_valid}, 32'd0);
        end
        chk("rst_mid_mem", mem[16], 32'h8001BEEF);
        ld("lw_after_rst", 3'b010, 32'h40, 32'h8001BEEF);

        // Back-to-back alternating SW/LW with req_valid held.
        bst[0] = 1'b1; bf3[0] = 3'b010; bad_a[0] = 32'h80; bwd[0] = 32'h11223344;
        bst[1] = 1'b0; bf3[1] = 3'b010; bad_a[1] = 32'h80; bwd[1] = 32'h0;
        bst[2] = 1'b1; bf3[2] = 3'b010; bad_a[2] = 32'h84; bwd[2] = 32'hCAFEF00D;
        bst[3] = 1'b0; bf3[3] = 3'b010; bad_a[3] = 32'h84; bwd[3] = 32'h0;
        idx   = 0;
        nresp = 0;
        for (int c = 0; c < 40 && nresp < 4; c++) begin
            @(negedge clk);
            if (idx < 4) begin
                bus.req_valid  = 1'b1;
                bus.req_store  = bst[idx];
                bus.req_funct3 = bf3[idx];
                bus.req_addr   = bad_a[idx];
                bus.req_wdata  = bwd[idx];
            end else begin
                bus.req_valid = 1'b0;
            end
            rdy_at = bus.req_ready;
            @(posedge clk);
            if (bus.req_valid && rdy_at) idx++;
            #1;
            if (bus.resp_valid) begin
                if (nresp < 4) brd[nresp] = bus.resp_rdata;
                nresp++;
            end
        end
        bus.req_valid = 1'b0;
        chk("b2b_accepts", idx, 4);
        chk("b2b_resps", nresp, 4);
        chk("b2b_lw0", brd[1], 32'h11223344);
        chk("b2b_lw1", brd[3], 32'hCAFEF00D);
        chk("b2b_sw_rdata", brd[0] | brd[2], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
